// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin front end that lets two requesters share one
// shift-add multiplier, with start/done sequencing and a WAIT watchdog.
module mult_share_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 err,
    output logic [2*WIDTH-1:0]   p0,
    output logic [2*WIDTH-1:0]   p1,
    output logic                 busy,
    output logic [WIDTH-1:0]     mula,
    output logic [WIDTH-1:0]     mulb,
    output logic                 mulst,
    input  logic                 muldone,
    input  logic                 mulidle,
    input  logic [2*WIDTH-1:0]   mulr
);
    localparam int PW  = 2 * WIDTH;
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0]   WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [WDW-1:0]   WD_ONE  = WDW'(1);
    localparam logic [WDW-1:0]   WD_ZERO = {WDW{1'b0}};
    localparam logic [PW-1:0]    P_ZERO  = {PW{1'b0}};
    localparam logic [WIDTH-1:0] OP_ZERO = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic             owner_r;
    logic             ptr_r;
    logic             err_r;
    logic [WDW-1:0]   wd_r;
    logic [PW-1:0]    p0_r;
    logic [PW-1:0]    p1_r;
    logic [WIDTH-1:0] mula_r;
    logic [WIDTH-1:0] mulb_r;
    logic             sel_req_s;
    logic             grant_port_s;
    logic             expire_s;

    // Next-state decode and round-robin grant selection.
    always_comb begin
        state_s      = state_r;
        sel_req_s    = ptr_r ? req1 : req0;
        grant_port_s = sel_req_s ? ptr_r : ~ptr_r;
        expire_s     = (wd_r == WD_LAST);
        case (state_r)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mulidle) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                // Done takes precedence over an expiring watchdog.
                if (muldone || expire_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant capture, watchdog, result registers and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r <= 1'b0;
            ptr_r   <= 1'b0;
            err_r   <= 1'b0;
            wd_r    <= WD_ZERO;
            p0_r    <= P_ZERO;
            p1_r    <= P_ZERO;
            mula_r  <= OP_ZERO;
            mulb_r  <= OP_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        owner_r <= grant_port_s;
                        mula_r  <= grant_port_s ? a1 : a0;
                        mulb_r  <= grant_port_s ? b1 : b0;
                    end
                end
                ST_WAIT: begin
                    wd_r <= wd_r + WD_ONE;
                    if (muldone) begin
                        if (owner_r) begin
                            p1_r <= mulr;
                        end else begin
                            p0_r <= mulr;
                        end
                        err_r <= 1'b0;
                    end else if (expire_s) begin
                        if (owner_r) begin
                            p1_r <= P_ZERO;
                        end else begin
                            p0_r <= P_ZERO;
                        end
                        err_r <= 1'b1;
                    end
                end
                ST_RESP: begin
                    ptr_r <= ~owner_r;
                    wd_r  <= WD_ZERO;
                    err_r <= 1'b0;
                end
                default: begin
                    wd_r <= WD_ZERO;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state, so reset clears them at once.
    assign mulst = (state_r == ST_ISSUE) && mulidle;
    assign busy  = (state_r != ST_IDLE);
    assign ack0  = (state_r == ST_RESP) && !owner_r;
    assign ack1  = (state_r == ST_RESP) && owner_r;
    assign err   = err_r;
    assign p0    = p0_r;
    assign p1    = p1_r;
    assign mula  = mula_r;
    assign mulb  = mulb_r;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: behavioural multiplier, job-level expectation model
// checked every cycle, and directed scenarios with hand-computed literals.
module tb_mult_share_arbiter;
    localparam int W  = 16;
    localparam int TO = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic ack0, ack1, err, busy, mulst;
    logic [2*W-1:0] p0, p1;
    logic [W-1:0] mula, mulb;
    logic muldone = 1'b0;
    logic mulidle;
    logic [2*W-1:0] mulr = '0;

    mult_share_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .err(err), .p0(p0), .p1(p1),
        .busy(busy), .mula(mula), .mulb(mulb), .mulst(mulst),
        .muldone(muldone), .mulidle(mulidle), .mulr(mulr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit          port;
        logic [31:0] prod;
        logic        e;
        int          ack_cycle;
    } job_t;
    job_t jobs[$];

    // Model state
    bit          ptr_m = 1'b0;
    logic [31:0] sh[2] = '{32'd0, 32'd0};
    logic [15:0] opa[2] = '{16'd0, 16'd0};
    logic [15:0] opb[2] = '{16'd0, 16'd0};
    int  lat = 1;            // 0: multiplier never finishes
    int  hold_extra = 0;     // extra cycles done stays high
    bit  force_busy = 1'b0;
    bit  running = 1'b0;
    bit  start_pending = 1'b0;
    int  start_cyc = 0;
    int  done_left = 0;
    int  mulst_cnt = 0;
    logic [31:0] res = '0;

    assign mulidle = !running && !force_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flush_model();
        jobs.delete();
        sh[0] = 32'd0;
        sh[1] = 32'd0;
        ptr_m = 1'b0;
        running = 1'b0;
        start_pending = 1'b0;
        done_left = 0;
        muldone = 1'b0;
    endtask

    task automatic raise(input bit port, input logic [15:0] a, input logic [15:0] b);
        opa[port] = a;
        opb[port] = b;
        if (port) begin a1 = a; b1 = b; req1 = 1'b1; end
        else      begin a0 = a; b0 = b; req0 = 1'b1; end
    endtask

    // port 2 = either port; returns the port seen and its cycle
    task automatic wait_ack(input int port, input int budget, output int which, output int at);
        bit got = 1'b0;
        which = -1;
        at = -1;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (port == 0)      got = ack0;
            else if (port == 1) got = ack1;
            else                got = ack0 | ack1;
            if (got) begin
                which = ack1 ? 1 : 0;
                at = cyc;
            end
        end
        chk($sformatf("ack_wait_port%0d", port), got, 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural multiplier; also records the job the arbiter must return.
    initial forever begin
        job_t j;
        @(negedge clk);
        if (!rst_n) begin
            running = 1'b0; start_pending = 1'b0; done_left = 0; muldone = 1'b0;
        end else begin
            if (mulst) begin
                mulst_cnt++;
                j.port = ((ptr_m ? req1 : req0) === 1'b1) ? ptr_m : !ptr_m;
                if (lat == 0) begin
                    j.e = 1'b1; j.prod = 32'd0; j.ack_cycle = cyc + TO + 1;
                end else begin
                    j.e = 1'b0;
                    j.prod = 32'(opa[j.port]) * 32'(opb[j.port]);
                    j.ack_cycle = cyc + lat + 1;
                    start_pending = 1'b1;
                    start_cyc = cyc;
                    res = 32'(mula) * 32'(mulb);
                end
                jobs.push_back(j);
            end
            if (running && cyc == start_cyc + lat) begin
                running = 1'b0;
                done_left = 1 + hold_extra;
                mulr = res;
            end
            muldone = (done_left > 0);
            if (done_left > 0) done_left--;
        end
        @(posedge clk);
        #1;
        if (start_pending && rst_n) begin
            running = 1'b1;
            start_pending = 1'b0;
        end
    end

    // Compare process: every cycle out of reset.
    initial forever begin
        job_t j;
        @(negedge clk);
        if (rst_n) begin
            chk("ack_exclusive", ack0 & ack1, 0);
            chk("mulst_needs_idle", mulst & ~mulidle, 0);
            if (ack0 || ack1) begin
                chk("job_pending_at_ack", jobs.size() > 0, 1);
                if (jobs.size() > 0) begin
                    j = jobs.pop_front();
                    chk("ack_port", ack1, j.port);
                    chk("ack_err", err, j.e);
                    chk("ack_cycle", cyc, j.ack_cycle);
                    sh[j.port] = j.prod;
                    ptr_m = !j.port;
                end
            end else begin
                chk("err_outside_ack", err, 0);
            end
            if (jobs.size() > 0 && cyc > jobs[0].ack_cycle) begin
                chk("ack_late", cyc, jobs[0].ack_cycle);
                void'(jobs.pop_front());
            end
            chk("p0_model", p0, sh[0]);
            chk("p1_model", p1, sh[1]);
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int which, at, n, st0;
        int order[4];

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_p0", p0, 0); chk("rst_p1", p1, 0);
        chk("rst_ack", {ack0, ack1}, 0); chk("rst_err", err, 0);
        chk("rst_busy", busy, 0); chk("rst_mulst", mulst, 0);
        chk("rst_mula", mula, 0); chk("rst_mulb", mulb, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request, 17-cycle multiplier
        lat = 17; st0 = mulst_cnt;
        raise(0, 16'd3, 16'd5);
        wait_ack(0, 60, which, at);
        chk("single_p0", p0, 15); chk("single_err", err, 0); chk("single_p1", p1, 0);
        chk("single_mulst_count", mulst_cnt - st0, 1);
        req0 = 1'b0;
        @(negedge clk);
        chk("single_ack_one_cycle", ack0, 0);

        // Simultaneous requests after reset
        rst_n = 1'b0; flush_model();
        @(negedge clk);
        rst_n = 1'b1;
        lat = 3;
        raise(0, 16'd2, 16'd2);
        raise(1, 16'd7, 16'd7);
        wait_ack(2, 40, which, at);
        chk("simul_first_port", which, 0); chk("simul_p0", p0, 4);
        req0 = 1'b0;
        wait_ack(1, 40, which, at);
        chk("simul_p1", p1, 49);
        req1 = 1'b0;
        @(negedge clk);

        // Fairness: both held, best-case latency
        lat = 1;
        n = cyc;
        raise(0, 16'd10, 16'd11);
        raise(1, 16'd12, 16'd13);
        for (int i = 0; i < 4; i++) begin
            wait_ack(2, 20, which, at);
            order[i] = at;
            chk($sformatf("fair_grant%0d", i), which, i % 2);
            if (i == 0) chk("req_to_ack_min", at - n, 3);
            else        chk($sformatf("fair_spacing%0d", i), at - order[i-1], 4);
        end
        chk("fair_p0", p0, 110); chk("fair_p1", p1, 156);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        // Busy multiplier holds ISSUE
        force_busy = 1'b1; lat = 2; st0 = mulst_cnt;
        raise(1, 16'd9, 16'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("busy_mulst_low", mulst, 0);
            chk("busy_flag", busy, 1);
        end
        @(posedge clk); #2;
        force_busy = 1'b0;
        wait_ack(1, 30, which, at);
        chk("busy_p1", p1, 81);
        chk("busy_mulst_count", mulst_cnt - st0, 1);
        req1 = 1'b0;
        @(negedge clk);

        // Timeout: never done
        lat = 0;
        n = cyc;
        raise(1, 16'd4, 16'd4);
        wait_ack(1, 100, which, at);
        chk("tmo_latency", at - n, 42);
        chk("tmo_err", err, 1); chk("tmo_p1", p1, 0);
        req1 = 1'b0;
        @(negedge clk);
        chk("tmo_idle_busy", busy, 0); chk("tmo_err_clear", err, 0);

        // Done on the watchdog's last cycle wins
        lat = 40;
        n = cyc;
        raise(0, 16'd100, 16'd200);
        wait_ack(0, 100, which, at);
        chk("edge_latency", at - n, 42);
        chk("edge_err", err, 0); chk("edge_p0", p0, 20000);
        req0 = 1'b0;
        @(negedge clk);

        // Held done and operand change after grant
        lat = 2; hold_extra = 3;
        raise(0, 16'd6, 16'd7);
        @(negedge clk);
        a0 = 16'd99; b0 = 16'd1;
        wait_ack(0, 20, which, at);
        chk("hold_p0", p0, 42);
        req0 = 1'b0;
        repeat (4) @(negedge clk);
        hold_extra = 0;
        chk("hold_no_reack", ack0, 0);

        // Request dropped after grant still completes
        lat = 5;
        raise(1, 16'd5, 16'd5);
        repeat (2) @(negedge clk);
        req1 = 1'b0;
        wait_ack(1, 20, which, at);
        chk("drop_p1", p1, 25);
        @(negedge clk);

        // Reset mid-WAIT, then a fresh transaction
        lat = 30;
        raise(0, 16'd8, 16'd9);
        repeat (6) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0); chk("mid_rst_ack", {ack0, ack1}, 0);
        chk("mid_rst_err", err, 0); chk("mid_rst_mulst", mulst, 0);
        chk("mid_rst_p0", p0, 0); chk("mid_rst_p1", p1, 0);
        flush_model();
        lat = 4;
        raise(0, 16'd11, 16'd13);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ack(0, 30, which, at);
        chk("post_rst_p0", p0, 143); chk("post_rst_err", err, 0);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("jobs_drained", jobs.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
